// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with a one-word holding
// buffer, MSB-first serial output, bit-valid and start-of-frame strobes.
// Ports: clk, clr (async active-high reset), pi/load in, rdy out (handshake),
//        so/so_vld/sof serial stream out, busy status out.
// Build option: define PISO_PARITY_EN to append an even-parity bit per frame.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] pi,
    input  logic             load,
    output logic             rdy,
    output logic             so,
    output logic             so_vld,
    output logic             sof,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
    logic r_par;
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_so;
    logic             r_so_vld;
    logic             r_sof;
    logic             r_busy;

    logic             w_accept;
    logic             w_data_end;
    logic             w_last;
    logic             w_start;
    logic [WIDTH-1:0] w_word;
    logic             w_hold_wr;
    logic             w_hold_full_nxt;
    logic [1:0]       w_state_nxt;

    assign rdy    = ~r_hold_full & ~clr;
    assign so     = r_so;
    assign so_vld = r_so_vld;
    assign sof    = r_sof;
    assign busy   = r_busy;

    always_comb begin
        w_accept   = load & ~r_hold_full;
        // r_cnt is the index of the bit currently on so
        w_data_end = (r_state == SHIFT) && (r_cnt == LAST);
`ifdef PISO_PARITY_EN
        w_last     = (r_state == PAR);
`else
        w_last     = w_data_end;
`endif
        // a new frame starts when the line is free at the next edge
        w_start    = ((r_state == IDLE) | w_last) & (r_hold_full | w_accept);
        w_word     = r_hold_full ? r_hold : pi;
        // bypassed words never touch the holding register
        w_hold_wr  = w_accept & ~w_start;

        w_hold_full_nxt = r_hold_full;
        if (w_start && r_hold_full)
            w_hold_full_nxt = 1'b0;
        else if (w_hold_wr)
            w_hold_full_nxt = 1'b1;

        w_state_nxt = r_state;
        if (w_start)
            w_state_nxt = SHIFT;
        else if (w_last)
            w_state_nxt = IDLE;
`ifdef PISO_PARITY_EN
        else if (w_data_end)
            w_state_nxt = PAR;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_so        <= 1'b0;
            r_so_vld    <= 1'b0;
            r_sof       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_busy      <= (w_state_nxt != IDLE) | w_hold_full_nxt;
            if (w_hold_wr)
                r_hold <= pi;

            if (w_start) begin
                // MSB goes straight to the output register; the rest queues
                r_so     <= w_word[WIDTH-1];
                r_shift  <= {w_word[WIDTH-2:0], 1'b0};
                r_cnt    <= '0;
                r_sof    <= 1'b1;
                r_so_vld <= 1'b1;
`ifdef PISO_PARITY_EN
                r_par    <= ^w_word;
`endif
            end else if ((r_state == SHIFT) && !w_data_end) begin
                r_so     <= r_shift[WIDTH-1];
                r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                r_cnt    <= r_cnt + CW'(1);
                r_sof    <= 1'b0;
                r_so_vld <= 1'b1;
`ifdef PISO_PARITY_EN
            end else if (w_data_end) begin
                r_so     <= r_par;
                r_cnt    <= '0;
                r_sof    <= 1'b0;
                r_so_vld <= 1'b1;
`endif
            end else begin
                r_so     <= 1'b0;
                r_cnt    <= '0;
                r_sof    <= 1'b0;
                r_so_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer. Accepted words are
// expanded into an expected bit stream; a monitor pops and compares each cycle.
module tb_piso_serializer;
    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic [W-1:0] pi;
    logic         load;
    logic         rdy;
    logic         so;
    logic         so_vld;
    logic         sof;
    logic         busy;

    piso_serializer #(.WIDTH(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .pi     (pi),
        .load   (load),
        .rdy    (rdy),
        .so     (so),
        .so_vld (so_vld),
        .sof    (sof),
        .busy   (busy)
    );

    typedef struct packed {
        logic b;
        logic s;
    } sbit_t;

    sbit_t        q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] sipo = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: an accepted word becomes WIDTH bits MSB-first (+ parity)
    always @(posedge clk) begin
        if (clr) begin
            q.delete();
        end else if (load && rdy) begin
            for (int i = W - 1; i >= 0; i--)
                q.push_back('{b: pi[i], s: (i == W - 1)});
`ifdef PISO_PARITY_EN
            q.push_back('{b: ^pi, s: 1'b0});
`endif
        end
    end

    // downstream left-shifting receiver driven by so
    always @(posedge clk)
        if (so_vld)
            sipo <= {sipo[W-2:0], so};

    always @(negedge clk) begin
        if (clr) begin
            chk("rst_so_vld", int'(so_vld), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rdy", int'(rdy), 0);
        end else begin
            int pend;
            pend = 0;
            for (int i = 1; i < q.size(); i++)
                if (q[i].s) pend++;
            chk("so_vld", int'(so_vld), int'(q.size() > 0));
            chk("busy", int'(busy), int'(q.size() > 0));
            chk("rdy", int'(rdy), int'(pend == 0));
            if (so_vld && q.size() > 0) begin
                chk("so", int'(so), int'(q[0].b));
                chk("sof", int'(sof), int'(q[0].s));
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        pi   = w;
        load = 1'b1;
        @(negedge clk);
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() > 0) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (busy || q.size() > 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        clr  = 1'b1;
        load = 1'b0;
        pi   = '0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single word 1011, then idle
        send(4'b1011);
        wait_idle();

        // back-to-back A,5 followed by a load that must be ignored
        send(4'hA);
        send(4'h5);
        pi   = 4'hF;
        load = 1'b1;
        repeat (2) @(posedge clk);
        #1 load = 1'b0;
        wait_idle();

`ifndef PISO_PARITY_EN
        // loopback into the receiver
        send(4'hC);
        repeat (5) @(posedge clk);
        #1 chk("loopback", int'(sipo), 32'hC);
        wait_idle();
`endif

        // abort during bit 2 of a frame
        send(4'b0110);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("abort_so", int'(so), 0);
        chk("abort_vld", int'(so_vld), 0);
        chk("abort_sof", int'(sof), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdy", int'(rdy), 0);
        @(negedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        #1 chk("release_rdy", int'(rdy), 1);
        repeat (4) @(posedge clk);
        #1;

        // random traffic, sometimes holding load high
        for (int c = 0; c < 400; c++) begin
            load = (c % 100 < 50) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
            pi   = W'($urandom);
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
